// File: rtl/range_burst_feeder_if.sv
// Sample stream into the range burst feeder: valid/ready handshake with a burst-final marker.
interface range_burst_feeder_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;

  modport master (output in_data, output in_valid, output in_last, input in_ready);
  modport slave  (input in_data, input in_valid, input in_last, output in_ready);
endinterface

// File: rtl/range_burst_feeder.sv
// Buffers one input burst, then replays it gap-free to the range finder as go/data/finish,
// never raising go and finish together.
module range_burst_feeder #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic                clock,
  input  logic                reset,
  range_burst_feeder_if.slave in_s,
  output logic [WIDTH-1:0]    data_in,
  output logic                go,
  output logic                finish,
  output logic [CW-1:0]       burst_len,
  output logic                truncated,
  output logic                burst_done
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {FILL, DISCARD, REPLAY} state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    n_q;
  logic [CW-1:0]    pos;
  logic             trunc_q;

  logic             xfer;
  logic [CW-1:0]    cnt_inc;
  logic [CW-1:0]    pos_inc;
  logic [CW-1:0]    rlen;
  logic [AW-1:0]    rd_idx;
  logic [WIDTH-1:0] first_data;

  always_comb begin
    xfer    = in_s.in_valid & in_s.in_ready;
    cnt_inc = cnt + CW'(1);
    pos_inc = pos + CW'(1);
    // A one-sample burst is replayed twice so go and finish land in separate cycles.
    rlen    = (n_q == CW'(1)) ? CW'(2) : n_q;
    rd_idx  = (n_q == CW'(1)) ? '0 : pos_inc[AW-1:0];
    // Sample 0 is still being written on the edge that closes a one-sample burst.
    first_data = (state == FILL && cnt == '0) ? in_s.in_data : mem[0];
  end

  always_ff @(posedge clock) begin
    if (!reset && state == FILL && xfer)
      mem[cnt[AW-1:0]] <= in_s.in_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= FILL;
      cnt            <= '0;
      n_q            <= '0;
      pos            <= '0;
      trunc_q        <= 1'b0;
      in_s.in_ready  <= 1'b0;
      data_in        <= '0;
      go             <= 1'b0;
      finish         <= 1'b0;
      burst_len      <= '0;
      truncated      <= 1'b0;
      burst_done     <= 1'b0;
    end else begin
      go         <= 1'b0;
      finish     <= 1'b0;
      burst_done <= 1'b0;
      data_in    <= '0;
      unique case (state)
        FILL: begin
          in_s.in_ready <= 1'b1;
          if (xfer) begin
            cnt <= cnt_inc;
            if (in_s.in_last) begin
              n_q           <= cnt_inc;
              trunc_q       <= 1'b0;
              state         <= REPLAY;
              in_s.in_ready <= 1'b0;
              pos           <= '0;
              data_in       <= first_data;
              go            <= 1'b1;
            end else if (cnt == CW'(DEPTH - 1)) begin
              n_q     <= cnt_inc;
              trunc_q <= 1'b1;
              state   <= DISCARD;
            end
          end
        end
        DISCARD: begin
          in_s.in_ready <= 1'b1;
          if (xfer && in_s.in_last) begin
            state         <= REPLAY;
            in_s.in_ready <= 1'b0;
            pos           <= '0;
            data_in       <= first_data;
            go            <= 1'b1;
          end
        end
        REPLAY: begin
          if (pos_inc == rlen) begin
            state         <= FILL;
            cnt           <= '0;
            in_s.in_ready <= 1'b1;
          end else begin
            in_s.in_ready <= 1'b0;
            pos           <= pos_inc;
            data_in       <= mem[rd_idx];
            if (pos_inc == rlen - CW'(1)) begin
              finish     <= 1'b1;
              burst_done <= 1'b1;
              burst_len  <= n_q;
              truncated  <= trunc_q;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_range_burst_feeder.sv
// Directed bench for range_burst_feeder with DEPTH=4 so truncation is reachable.
module tb_range_burst_feeder;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clock = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] data_in;
  logic             go;
  logic             finish;
  logic [CW-1:0]    burst_len;
  logic             truncated;
  logic             burst_done;

  int checks   = 0;
  int failures = 0;

  range_burst_feeder_if #(.WIDTH(WIDTH)) bus ();

  range_burst_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_s       (bus.slave),
    .data_in    (data_in),
    .go         (go),
    .finish     (finish),
    .burst_len  (burst_len),
    .truncated  (truncated),
    .burst_done (burst_done)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    checks++;
    assert (!(go && finish)) else begin
      failures++;
      $error("FAIL go_finish_overlap observed=%0b%0b required=not both", go, finish);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Packed view of the replay outputs: {data_in, go, finish, burst_done}.
  task automatic out(input string tag, input logic [WIDTH-1:0] d, input logic g,
                     input logic f, input logic b);
    chk(tag, {13'd0, data_in, go, finish, burst_done}, {13'd0, d, g, f, b});
  endtask

  task automatic send(input string tag, input logic [WIDTH-1:0] d, input logic last);
    chk({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = 16'hdead;
  endtask

  initial begin
    reset        = 1'b1;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    tick();
    tick();
    chk("rst_ready", 32'(bus.in_ready), 32'd0);
    out("rst_out", 16'd0, 1'b0, 1'b0, 1'b0);
    chk("rst_len", 32'(burst_len), 32'd0);
    chk("rst_trunc", 32'(truncated), 32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_ready", 32'(bus.in_ready), 32'd1);

    // 1: four-sample burst, continuous valid
    send("t1_a", 16'd5, 1'b0);
    send("t1_b", 16'd9, 1'b0);
    send("t1_c", 16'd2, 1'b0);
    send("t1_d", 16'd7, 1'b1);
    chk("t1_ready_drop", 32'(bus.in_ready), 32'd0);
    out("t1_r0", 16'd5, 1'b1, 1'b0, 1'b0);
    tick(); out("t1_r1", 16'd9, 1'b0, 1'b0, 1'b0);
    tick(); out("t1_r2", 16'd2, 1'b0, 1'b0, 1'b0);
    tick(); out("t1_r3", 16'd7, 1'b0, 1'b1, 1'b1);
    chk("t1_len", 32'(burst_len), 32'd4);
    chk("t1_trunc", 32'(truncated), 32'd0);
    tick(); out("t1_idle", 16'd0, 1'b0, 1'b0, 1'b0);
    chk("t1_ready_back", 32'(bus.in_ready), 32'd1);

    // 2: single sample replayed twice
    send("t2", 16'd42, 1'b1);
    out("t2_r0", 16'd42, 1'b1, 1'b0, 1'b0);
    tick(); out("t2_r1", 16'd42, 1'b0, 1'b1, 1'b1);
    chk("t2_len", 32'(burst_len), 32'd1);
    tick(); out("t2_idle", 16'd0, 1'b0, 1'b0, 1'b0);

    // 3: six samples into DEPTH=4, tail dropped
    send("t3_1", 16'd1, 1'b0);
    send("t3_2", 16'd2, 1'b0);
    send("t3_3", 16'd3, 1'b0);
    send("t3_4", 16'd4, 1'b0);
    send("t3_5", 16'd5, 1'b0);
    send("t3_6", 16'd6, 1'b1);
    out("t3_r0", 16'd1, 1'b1, 1'b0, 1'b0);
    tick(); out("t3_r1", 16'd2, 1'b0, 1'b0, 1'b0);
    tick(); out("t3_r2", 16'd3, 1'b0, 1'b0, 1'b0);
    tick(); out("t3_r3", 16'd4, 1'b0, 1'b1, 1'b1);
    chk("t3_len", 32'(burst_len), 32'd4);
    chk("t3_trunc", 32'(truncated), 32'd1);
    tick(); out("t3_idle", 16'd0, 1'b0, 1'b0, 1'b0);

    // 4: stray in_last without valid, idle gaps inside the burst
    bus.in_last = 1'b1;
    bus.in_data = 16'd99;
    tick();
    bus.in_last = 1'b0;
    out("t4_stray_last", 16'd0, 1'b0, 1'b0, 1'b0);
    send("t4_a", 16'd3, 1'b0);
    bus.in_last = 1'b1;
    tick(); tick(); tick();
    bus.in_last = 1'b0;
    out("t4_gap", 16'd0, 1'b0, 1'b0, 1'b0);
    chk("t4_trunc_hold", 32'(truncated), 32'd1);
    chk("t4_len_hold", 32'(burst_len), 32'd4);
    send("t4_b", 16'd8, 1'b1);
    out("t4_r0", 16'd3, 1'b1, 1'b0, 1'b0);
    tick(); out("t4_r1", 16'd8, 1'b0, 1'b1, 1'b1);
    chk("t4_len", 32'(burst_len), 32'd2);
    chk("t4_trunc", 32'(truncated), 32'd0);
    tick();

    // 5: reset during the second replay cycle
    send("t5_1", 16'd10, 1'b0);
    send("t5_2", 16'd11, 1'b0);
    send("t5_3", 16'd12, 1'b0);
    send("t5_4", 16'd13, 1'b0);
    send("t5_5", 16'd14, 1'b0);
    send("t5_6", 16'd15, 1'b1);
    out("t5_r0", 16'd10, 1'b1, 1'b0, 1'b0);
    tick(); out("t5_r1", 16'd11, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    out("t5_abort", 16'd0, 1'b0, 1'b0, 1'b0);
    chk("t5_len", 32'(burst_len), 32'd0);
    chk("t5_ready", 32'(bus.in_ready), 32'd0);
    reset = 1'b0;
    tick();
    chk("t5_ready_back", 32'(bus.in_ready), 32'd1);
    out("t5_idle", 16'd0, 1'b0, 1'b0, 1'b0);
    send("t5_a", 16'd4, 1'b0);
    send("t5_b", 16'd4, 1'b1);
    out("t5_n0", 16'd4, 1'b1, 1'b0, 1'b0);
    tick(); out("t5_n1", 16'd4, 1'b0, 1'b1, 1'b1);
    chk("t5_new_len", 32'(burst_len), 32'd2);
    tick();

    // 6: back-to-back bursts
    send("t6_1", 16'd1, 1'b0);
    send("t6_2", 16'd2, 1'b1);
    out("t6_r0", 16'd1, 1'b1, 1'b0, 1'b0);
    tick(); out("t6_r1", 16'd2, 1'b0, 1'b1, 1'b1);
    chk("t6_len_a", 32'(burst_len), 32'd2);
    tick(); out("t6_gap", 16'd0, 1'b0, 1'b0, 1'b0);
    send("t6_3", 16'd3, 1'b0);
    send("t6_4", 16'd4, 1'b0);
    send("t6_5", 16'd5, 1'b1);
    out("t6_s0", 16'd3, 1'b1, 1'b0, 1'b0);
    tick(); out("t6_s1", 16'd4, 1'b0, 1'b0, 1'b0);
    tick(); out("t6_s2", 16'd5, 1'b0, 1'b1, 1'b1);
    chk("t6_len_b", 32'(burst_len), 32'd3);
    chk("t6_trunc", 32'(truncated), 32'd0);
    tick(); out("t6_idle", 16'd0, 1'b0, 1'b0, 1'b0);
    chk("t6_ready", 32'(bus.in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/range_burst_feeder.md
Name: range_burst_feeder

Overview:
- Upstream feeder for the range finder. Accepts samples on a valid/ready stream with a last marker and buffers one whole burst.
- Replays the buffered burst as an unbroken go/data/finish sequence, one sample per cycle, because the range finder samples every cycle while running and cannot tolerate gaps.
- Prevents the range finder's illegal go+finish and finish-while-idle sequences.

Parameters:
WIDTH, 16, sample width; must match the range finder WIDTH.
DEPTH, 16, max samples per burst (>=2); count fields are $clog2(DEPTH+1) bits (CW).

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high; clears all state
in_data  in  WIDTH  incoming sample
in_valid  in  1  in_data valid
in_last  in  1  sample is final of burst (qualified by in_valid)
in_ready  out  1  feeder can accept a sample
data_in  out  WIDTH  sample to range finder
go  out  1  start strobe to range finder
finish  out  1  end strobe to range finder
burst_len  out  CW  samples replayed in last completed burst
truncated  out  1  last completed burst exceeded DEPTH
burst_done  out  1  one-cycle pulse on final replay cycle

Behaviour:
- All outputs registered. Reset values: in_ready=0 while reset high, go=0, finish=0, data_in=0, burst_len=0, truncated=0, burst_done=0.
- In the first cycle after reset deasserts: state FILL and in_ready=1.
- States: FILL, DISCARD, REPLAY.
- A transfer occurs on a clock edge with in_valid & in_ready.
- FILL:
  - in_ready=1; each transfer writes in_data to buf[cnt] and increments cnt.
  - Transfer with in_last=1 -> REPLAY, n=cnt+1.
  - Transfer of sample number DEPTH with in_last=0 -> DISCARD, n=DEPTH, trunc flag set.
- DISCARD:
  - in_ready=1; transfers are dropped.
  - Transfer with in_last=1 -> REPLAY.
- REPLAY:
  - in_ready=0.
  - The first replay cycle is the cycle directly after the edge that entered REPLAY.
  - Replay index i runs 0..n-1, one per cycle, with no gaps; data_in=buf[i].
  - go=1 only at i=0; finish=1 only at i=n-1.
  - n=1 is a special case, to avoid go&finish: replay buf[0] twice, go in cycle 0 and finish in cycle 1 (range = 0).
  - On the finish cycle: burst_done=1, burst_len=n, truncated=trunc flag.
  - Next state FILL, cnt cleared; in_ready=1 in the following cycle.
- go and finish are never high in the same cycle.
- data_in=0, go=0 and finish=0 whenever not in REPLAY.
- burst_len and truncated hold until the next burst_done.
- in_valid=0 in FILL or DISCARD: no state change. Arbitrary idle gaps between input samples are allowed.
- in_data/in_last are ignored when no transfer occurs, including in_last without in_valid.
- Reset mid-REPLAY: replay aborts. go, finish and burst_done are low in the cycle after the reset edge, and buffer contents are discarded. The range finder shares the reset.
- Throughput: burst of n>=2 takes n fill transfers plus n replay cycles. Back-to-back bursts are allowed with no extra bubbles.

Test Plan:
1. Burst 5,9,2,7(last) with continuous valid:
   - in_ready drops the cycle after the edge accepting 7.
   - Next 4 cycles: data_in=5,9,2,7; go only with 5, finish only with 7.
   - burst_done with burst_len=4, truncated=0.
   - in_ready=1 one cycle later.
2. Single sample 42(last):
   - Replay is 2 cycles: data_in=42 with go=1, then data_in=42 with finish=1.
   - burst_len=1; go and finish never coincide.
3. DEPTH=4, burst 1,2,3,4,5,6(last):
   - 5 and 6 accepted but dropped.
   - Replay 1,2,3,4 with finish on 4; truncated=1, burst_len=4.
4. Burst 3,8(last) with in_valid low for 3 cycles between samples:
   - Replay is still contiguous: 3 with go, then 8 with finish in the next cycle.
   - in_last asserted with in_valid=0 beforehand has no effect.
5. Reset asserted during the 2nd replay cycle of a 6-sample burst:
   - The cycle after: go=finish=burst_done=0, data_in=0, burst_len=0.
   - After release: in_ready=1; a new burst 4,4(last) replays correctly.
6. Two back-to-back bursts 1,2(last), 3,4,5(last):
   - Two replays of lengths 2 and 3, each with exactly one go and one finish.
   - burst_len=2 then 3.
